// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int NREQ  = 4;
  localparam int DEPTH = 480;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef logic [IDW-1:0] req_id_t;

  // Per-port record of what was issued to the SRAM, carried into the response cycle.
  typedef struct packed {
    logic    valid;
    logic    is_read;
    req_id_t id;
  } port_tag_t;

endpackage

// File: rtl/sram_arb_rr_pick.sv
// Round-robin scan of a request mask starting at ptr_i; returns the first two hits one-hot.
module sram_arb_rr_pick
  import sram_arb_pkg::*;
#(
  parameter int N = NREQ
) (
  input  logic [N-1:0] mask_i,
  input  req_id_t      ptr_i,
  output logic [N-1:0] first_o,
  output logic [N-1:0] second_o
);

  req_id_t idx;
  logic    got_first;
  logic    got_second;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    first_o    = '0;
    second_o   = '0;
    got_first  = 1'b0;
    got_second = 1'b0;
    idx        = '0;
    for (int k = 0; k < N; k++) begin
      idx = req_id_t'((int'(ptr_i) + k) % N);
      if (mask_i[idx]) begin
        if (!got_first) begin
          first_o[idx] = 1'b1;
          got_first    = 1'b1;
        end else if (!got_second) begin
          second_o[idx] = 1'b1;
          got_second    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Round-robin arbiter mapping NREQ requesters onto a two-port SRAM with one-cycle read return.
// Optional build macro SRAM_ARB_RANGE_CHK_EN adds out-of-range address detection and the err port.
module sram_arb_ctrl #(
  parameter int NREQ  = sram_arb_pkg::NREQ,
  parameter int DEPTH = sram_arb_pkg::DEPTH,
  parameter int AW    = sram_arb_pkg::AW,
  parameter int DW    = sram_arb_pkg::DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*4-1:0] req_wea,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [NREQ*DW-1:0] rsp_rdata,
  output logic [3:0]        wea0,
  output logic [AW-1:0]     addr0,
  output logic [DW-1:0]     wdata0,
  input  logic [DW-1:0]     rdata0,
  output logic [3:0]        wea1,
  output logic [AW-1:0]     addr1,
  output logic [DW-1:0]     wdata1,
  input  logic [DW-1:0]     rdata1
`ifdef SRAM_ARB_RANGE_CHK_EN
  ,
  output logic [NREQ-1:0]   err
`endif
);

  import sram_arb_pkg::*;

  logic [AW-1:0]   addr_a  [NREQ];
  logic [3:0]      wea_a   [NREQ];
  logic [DW-1:0]   wdata_a [NREQ];
  logic [NREQ-1:0] is_rd;
  logic [NREQ-1:0] pick_mask, first_oh, second_oh, grant_vec;
  req_id_t         id0, id1, last, rr_ptr_q, rr_ptr_d;
  logic            g0, g1;
  port_tag_t       tag0_q, tag0_d, tag1_q, tag1_d;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i]  = req_addr[i*AW +: AW];
      wea_a[i]   = req_wea[i*4 +: 4];
      wdata_a[i] = req_wdata[i*DW +: DW];
      is_rd[i]   = (req_wea[i*4 +: 4] == 4'b0000);
    end
  end

`ifdef SRAM_ARB_RANGE_CHK_EN
  logic [NREQ-1:0] in_range, oor_acc, err_q, oor_rd_q;

  always_comb begin
    for (int i = 0; i < NREQ; i++) in_range[i] = (addr_a[i] < AW'(DEPTH));
  end

  // Out-of-range requests are accepted directly and never reach the picker.
  assign oor_acc   = rst ? '0 : (req_valid & ~in_range);
  assign pick_mask = rst ? '0 : (req_valid & in_range);
  assign req_ready = grant_vec | oor_acc;
  assign err       = err_q;
`else
  assign pick_mask = rst ? '0 : req_valid;
  assign req_ready = grant_vec;
`endif

  sram_arb_rr_pick #(.N(NREQ)) u_pick (
    .mask_i   (pick_mask),
    .ptr_i    (rr_ptr_q),
    .first_o  (first_oh),
    .second_o (second_oh)
  );

  always_comb begin
    id0 = '0;
    id1 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (first_oh[i])  id0 = req_id_t'(i);
      if (second_oh[i]) id1 = req_id_t'(i);
    end
    g0 = |first_oh;
    // The second pick waits rather than hit the same word as port 0.
    g1 = (|second_oh) && (addr_a[id1] != addr_a[id0]);
    grant_vec = (g0 ? first_oh : '0) | (g1 ? second_oh : '0);

    wea0   = g0 ? wea_a[id0]   : '0;
    addr0  = g0 ? addr_a[id0]  : '0;
    wdata0 = g0 ? wdata_a[id0] : '0;
    wea1   = g1 ? wea_a[id1]   : '0;
    addr1  = g1 ? addr_a[id1]  : '0;
    wdata1 = g1 ? wdata_a[id1] : '0;

    last     = g1 ? id1 : id0;
    rr_ptr_d = rr_ptr_q;
    if (g0) rr_ptr_d = (int'(last) == NREQ - 1) ? '0 : last + req_id_t'(1);

    tag0_d = '{valid: g0, is_read: g0 && is_rd[id0], id: id0};
    tag1_d = '{valid: g1, is_read: g1 && is_rd[id1], id: id1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      tag0_q   <= '0;
      tag1_q   <= '0;
`ifdef SRAM_ARB_RANGE_CHK_EN
      err_q    <= '0;
      oor_rd_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rr_ptr_q <= rr_ptr_d;
      tag0_q   <= tag0_d;
      tag1_q   <= tag1_d;
`ifdef SRAM_ARB_RANGE_CHK_EN
      err_q    <= oor_acc;
      oor_rd_q <= oor_acc & is_rd;
`endif
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (tag0_q.valid && tag0_q.is_read) begin
      rsp_valid[tag0_q.id]             = 1'b1;
      rsp_rdata[tag0_q.id*DW +: DW]    = rdata0;
    end
    if (tag1_q.valid && tag1_q.is_read) begin
      rsp_valid[tag1_q.id]             = 1'b1;
      rsp_rdata[tag1_q.id*DW +: DW]    = rdata1;
    end
`ifdef SRAM_ARB_RANGE_CHK_EN
    rsp_valid = rsp_valid | oor_rd_q;
`endif
  end

endmodule

// File: doc/sram_arb_ctrl.md
SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

Interface
REQ-001 Parameters SHALL be, as name / default / meaning:
- NREQ / 4 / requester count
- DEPTH / 480 / SRAM words
- AW / 16 / address width
- DW / 32 / data width
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req_valid  input  NREQ  per-requester access request.
REQ-005 req_ready  output  NREQ  grant; the access is accepted in any cycle where valid and ready are both high.
REQ-006 req_addr  input  NREQ*AW  word address; requester i at [i*AW +: AW].
REQ-007 req_wea  input  NREQ*4  byte write enables; all zero means a read.
REQ-008 req_wdata  input  NREQ*DW  write data.
REQ-009 rsp_valid  output  NREQ  one-cycle read-data-valid pulse per requester.
REQ-010 rsp_rdata  output  NREQ*DW  read data per requester.
REQ-011 wea0/addr0/wdata0  output  4/AW/DW  SRAM port 0 drive.
REQ-012 rdata0  input  DW  SRAM port 0 read data.
REQ-013 wea1/addr1/wdata1  output  4/AW/DW  SRAM port 1 drive.
REQ-014 rdata1  input  DW  SRAM port 1 read data.
REQ-015 err  output  NREQ  range-error pulse; present only under SRAM_ARB_RANGE_CHK_EN.

Function
REQ-016 Each cycle, the block SHALL scan req_valid in round-robin order starting at rr_ptr.
- The first valid requester is granted port 0.
- The next valid requester is granted port 1, unless its address equals the port 0 address; in that case it waits.
REQ-017 The grant SHALL be combinational: req_ready and the SRAM port signals are driven in the same cycle as the grant; the SRAM samples them at the next edge.
REQ-018 An idle port SHALL drive wea=0, addr=0, wdata=0.
REQ-019 rr_ptr SHALL advance to (last granted index + 1) mod NREQ, and hold when nothing is granted.
REQ-020 For a read granted in cycle N, rsp_valid[id] SHALL pulse in cycle N+1, with rsp_rdata[id] taken from the rdata of the granted port.
REQ-021 The granted requester id and port SHALL be registered per port for that cycle; non-asserted rsp_rdata lanes SHALL read 0.
REQ-022 Writes SHALL produce no response and complete at the grant edge.
REQ-023 A read granted the cycle after a write to the same address SHALL return the new data.
REQ-024 No more than two grants SHALL issue per cycle, and never two to the same address.
REQ-025 A requester holding req_valid SHALL be granted within NREQ cycles (no starvation).

Reset
REQ-026 While rst is high: rr_ptr=0, rsp_valid=0, rsp_rdata=0, err=0, registered tags cleared, req_ready=0, SRAM ports idle.
REQ-027 A read granted in the cycle rst asserts SHALL produce no response.

Configuration
REQ-028 With SRAM_ARB_RANGE_CHK_EN defined, a request with addr >= DEPTH SHALL be:
- accepted (ready) but not issued to SRAM and not counted as a port grant;
- followed by err[id] pulsing in cycle N+1;
- if a read, also followed by rsp_valid[id] in N+1 with rsp_rdata 0.
REQ-029 Without SRAM_ARB_RANGE_CHK_EN, addresses SHALL be forwarded unchecked, and the err port and its logic SHALL be absent.

Structure
REQ-030 Package sram_arb_pkg SHALL hold NREQ, DEPTH, AW, DW, typedef req_id_t (clog2 NREQ bits), and the port tag struct {valid, is_read, id}.
REQ-031 Round-robin selection SHALL live in sub-module sram_arb_rr_pick: inputs a mask and a pointer; outputs first/second one-hot picks.

Verification
REQ-032 Requesters 0..3 all read addr 0x10,0x11,0x12,0x13 at rr_ptr=0 -> cycle 0 grants 0,1; cycle 1 grants 2,3; rsp_valid 0,1 then 2,3 with correct data.
REQ-033 Req0 write 0xA5A5A5A5 (wea=4'b1111) and req1 read, both to addr 0x20 -> only req0 granted; req1 granted next cycle and returns 0xA5A5A5A5.
REQ-034 Byte write wea=4'b0010 data 0x0000CD00 to a word holding 0x11223344, then read -> 0x1122CD44.
REQ-035 Req2 held valid continuously while req0/1/3 are also valid -> req2 granted within 4 cycles, and rr_ptr rotation matches REQ-019.
REQ-036 rst asserted during a cycle with two reads granted -> no rsp_valid the following cycle; rr_ptr=0 after release.
REQ-037 With SRAM_ARB_RANGE_CHK_EN, a read of addr 480 (0x01E0) -> ready=1, SRAM ports idle, err and rsp_valid pulse next cycle, rsp_rdata=0.
